// File: rtl/trigger_network_sync.sv
// trigger_network_sync
// Network-level companion to the per-actor trigger FSMs. It does three things:
//   * sequences the network's ap_* handshake,
//   * issues a one-cycle start to every trigger,
//   * reduces the per-trigger sleep/sync status into registered broadcasts.
// It also stretches external enqueue pulses into a held external_enqueue level.
// Every output comes from a register or is decoded from registered state.

module trigger_network_sync #(
    parameter int NUM_ACTORS = 4,
    parameter int NUM_INPUTS = 1,
    parameter int ENQ_HOLD   = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    input  logic [NUM_ACTORS-1:0] actor_sleep,
    input  logic [NUM_ACTORS-1:0] actor_sync_exec,
    input  logic [NUM_ACTORS-1:0] actor_sync_wait,
    input  logic [NUM_ACTORS-1:0] actor_done,
    input  logic [NUM_INPUTS-1:0] enqueue_pulse,
    output logic [NUM_ACTORS-1:0] trigger_start,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait,
    output logic                  external_enqueue
);

    localparam int               CNT_W    = $clog2(ENQ_HOLD + 1);
    localparam logic [CNT_W-1:0] ENQ_LOAD = CNT_W'(ENQ_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_ACTORS-1:0]   done_mask_q, done_mask_d;
    logic [CNT_W-1:0]        enq_cnt_q, enq_cnt_d;
    logic                    enq_active_d;
    logic                    ext_enq_q;
    logic                    all_sleep_q, all_sleep_d;
    logic                    all_sync_q, all_sync_d;
    logic                    all_sync_wait_q, all_sync_wait_d;
    logic                    run;

    assign run = (state_q == ST_RUN);

    // Next-state logic for the network handshake and the sticky done mask.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        done_mask_d = done_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) state_d = ST_START;
            end
            ST_START: begin
                done_mask_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // The mask includes this cycle's actor_done, so a final bit that
                // arrives on the last RUN cycle still completes the run.
                done_mask_d = done_mask_q | actor_done;
                if (&done_mask_d) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Enqueue hold counter: reload on any pulse, otherwise count down to zero; idle outside RUN.
    always_comb begin
        enq_cnt_d = '0;
        if (run) begin
            if (|enqueue_pulse) begin
                enq_cnt_d = ENQ_LOAD;
            end else if (enq_cnt_q != '0) begin
                enq_cnt_d = enq_cnt_q - CNT_W'(1);
            end
        end
    end

    // Sleep suppression is judged on the same count that drives external_enqueue
    // next cycle, so the two broadcasts never disagree about pending external data.
    assign enq_active_d = (enq_cnt_d != '0);

    // Status reductions, registered so the broadcasts lag their inputs by exactly one cycle.
    always_comb begin
        all_sleep_d     = run & (&actor_sleep) & ~enq_active_d;
        all_sync_d      = run & (&(actor_sync_exec | actor_sync_wait));
        all_sync_wait_d = run & (&actor_sync_wait);
    end

    // State, mask, counter and broadcast registers; everything clears on reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= ST_IDLE;
            done_mask_q     <= '0;
            enq_cnt_q       <= '0;
            ext_enq_q       <= 1'b0;
            all_sleep_q     <= 1'b0;
            all_sync_q      <= 1'b0;
            all_sync_wait_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            done_mask_q     <= done_mask_d;
            enq_cnt_q       <= enq_cnt_d;
            ext_enq_q       <= enq_active_d;
            all_sleep_q     <= all_sleep_d;
            all_sync_q      <= all_sync_d;
            all_sync_wait_q <= all_sync_wait_d;
        end
    end

    // Outputs decoded from registered state only.
    assign ap_idle          = (state_q == ST_IDLE);
    assign ap_done          = (state_q == ST_DONE);
    assign ap_ready         = (state_q == ST_DONE);
    assign trigger_start    = {NUM_ACTORS{state_q == ST_START}};
    assign all_sleep        = all_sleep_q;
    assign all_sync         = all_sync_q;
    assign all_sync_wait    = all_sync_wait_q;
    assign external_enqueue = ext_enq_q;

endmodule

// File: tb/tb_trigger_network_sync.sv
// Testbench for trigger_network_sync (NUM_ACTORS=4, NUM_INPUTS=1, ENQ_HOLD=8).
// Expected output snapshots are queued as stimulus is driven and popped when
// the DUT outputs are sampled, 1 time unit after the rising edge.

module tb_trigger_network_sync;

    localparam int NA = 4;
    localparam int NI = 1;
    localparam int EH = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done, ap_ready, ap_idle;
    logic [NA-1:0] actor_sleep, actor_sync_exec, actor_sync_wait, actor_done;
    logic [NI-1:0] enqueue_pulse;
    logic [NA-1:0] trigger_start;
    logic          all_sleep, all_sync, all_sync_wait, external_enqueue;

    typedef struct packed {
        logic          idle;
        logic          done;
        logic          ready;
        logic [NA-1:0] tstart;
        logic          sleep;
        logic          sync;
        logic          syncw;
        logic          enq;
    } outs_t;

    localparam outs_t O_IDLE  = outs_t'(11'b1_0_0_0000_0_0_0_0);
    localparam outs_t O_START = outs_t'(11'b0_0_0_1111_0_0_0_0);
    localparam outs_t O_RUN   = outs_t'(11'b0_0_0_0000_0_0_0_0);
    localparam outs_t O_DONE  = outs_t'(11'b0_1_1_0000_0_0_0_0);

    outs_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    trigger_network_sync #(
        .NUM_ACTORS(NA),
        .NUM_INPUTS(NI),
        .ENQ_HOLD  (EH)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_ready        (ap_ready),
        .ap_idle         (ap_idle),
        .actor_sleep     (actor_sleep),
        .actor_sync_exec (actor_sync_exec),
        .actor_sync_wait (actor_sync_wait),
        .actor_done      (actor_done),
        .enqueue_pulse   (enqueue_pulse),
        .trigger_start   (trigger_start),
        .all_sleep       (all_sleep),
        .all_sync        (all_sync),
        .all_sync_wait   (all_sync_wait),
        .external_enqueue(external_enqueue)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic outs_t snap();
        snap = {ap_idle, ap_done, ap_ready, trigger_start,
                all_sleep, all_sync, all_sync_wait, external_enqueue};
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_inputs();
        ap_start        = 1'b0;
        actor_sleep     = '0;
        actor_sync_exec = '0;
        actor_sync_wait = '0;
        actor_done      = '0;
        enqueue_pulse   = '0;
    endtask

    // Drive IDLE -> START -> RUN without checking (covered by test_basic_run).
    task automatic start_run();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
    endtask

    // Complete all actors and return to IDLE without checking.
    task automatic finish_run();
        clear_inputs();
        actor_done = '1;
        tick();
        actor_done = '0;
        tick();
    endtask

    task automatic test_reset();
        outs_t got, exp;
        clear_inputs();
        ap_rst_n = 1'b0;
        #3;
        exp_q.push_back(O_IDLE);
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", got, exp);
        end
        ap_start = 1'b1;
        exp_q.push_back(O_IDLE);
        tick();
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_hold_start: got %b expected %b", got, exp);
        end
        ap_start = 1'b0;
        ap_rst_n = 1'b1;
        exp_q.push_back(O_IDLE);
        tick();
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_release: got %b expected %b", got, exp);
        end
    endtask

    // ap_start sampled at edge 0; done bits 0,1 at edge 10 and bits 2,3 at edge 14.
    task automatic test_basic_run();
        outs_t got, exp;
        for (int e = 0; e <= 16; e++) begin
            ap_start   = (e == 0);
            actor_done = (e == 10) ? 4'h3 : (e == 14) ? 4'hC : 4'h0;
            if (e == 0)       exp_q.push_back(O_START);
            else if (e < 14)  exp_q.push_back(O_RUN);
            else if (e == 14) exp_q.push_back(O_DONE);
            else              exp_q.push_back(O_IDLE);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic_run edge %0d: got %b expected %b", e, got, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_sleep_gating();
        outs_t got, exp;
        logic [NA-1:0] sl [2] = '{4'hF, 4'h7};
        start_run();
        for (int i = 0; i < 2; i++) begin
            actor_sleep = sl[i];
            exp = O_RUN;
            exp.sleep = (i == 0);
            exp_q.push_back(exp);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sleep_gating sleep=%h: got %b expected %b", sl[i], got, exp);
            end
        end
        finish_run();
    endtask

    task automatic test_enqueue_hold();
        outs_t got, exp;
        int    second [2] = '{7, 8};
        start_run();
        actor_sleep = 4'hF;
        // Single pulse: held for EH cycles, then sleep released the first cycle after.
        for (int j = 0; j <= EH; j++) begin
            enqueue_pulse = (j == 0);
            exp = O_RUN;
            exp.enq   = (j < EH);
            exp.sleep = !(j < EH);
            exp_q.push_back(exp);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL enq_single edge %0d: got %b expected %b", j, got, exp);
            end
        end
        // Second pulse during the hold (s=8 lands when the count is at 1).
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j <= second[k] + EH; j++) begin
                enqueue_pulse = (j == 0) || (j == second[k]);
                exp = O_RUN;
                exp.enq   = (j < second[k] + EH);
                exp.sleep = !(j < second[k] + EH);
                exp_q.push_back(exp);
                tick();
                got = snap(); exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL enq_extend s=%0d edge %0d: got %b expected %b",
                             second[k], j, got, exp);
                end
            end
        end
        finish_run();
    endtask

    task automatic test_sync_reductions();
        outs_t got, exp;
        logic [NA-1:0] ex [4] = '{4'h3, 4'h0, 4'h1, 4'h6};
        logic [NA-1:0] wt [4] = '{4'hC, 4'hF, 4'hC, 4'h9};
        logic          sy [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic          sw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        start_run();
        for (int i = 0; i < 4; i++) begin
            actor_sync_exec = ex[i];
            actor_sync_wait = wt[i];
            exp = O_RUN;
            exp.sync  = sy[i];
            exp.syncw = sw[i];
            exp_q.push_back(exp);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sync exec=%h wait=%h: got %b expected %b", ex[i], wt[i], got, exp);
            end
        end
        finish_run();
        // All status inputs high while IDLE: broadcasts stay low.
        actor_sleep     = '1;
        actor_sync_exec = '1;
        actor_sync_wait = '1;
        enqueue_pulse   = '1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(O_IDLE);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sync_idle cycle %0d: got %b expected %b", i, got, exp);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_run();
        outs_t got, exp;
        start_run();
        enqueue_pulse = 1'b1;
        actor_done    = 4'h3;
        tick();
        enqueue_pulse = 1'b0;
        actor_done    = 4'h0;
        tick();
        tick();
        tick();
        exp = O_RUN;
        exp.enq = 1'b1;
        exp_q.push_back(exp);
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midrst_before: got %b expected %b", got, exp);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        exp_q.push_back(O_IDLE);
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midrst_async: got %b expected %b", got, exp);
        end
        tick();
        ap_rst_n = 1'b1;
        start_run();
        // Bits 2,3 alone must not finish: the pre-reset bits 0,1 are gone.
        for (int e = 0; e < 6; e++) begin
            actor_done = (e < 5) ? 4'hC : 4'h3;
            exp_q.push_back((e < 5) ? O_RUN : O_DONE);
            tick();
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midrst_fresh edge %0d: got %b expected %b", e, got, exp);
            end
        end
        actor_done = '0;
        exp_q.push_back(O_IDLE);
        tick();
        got = snap(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midrst_idle: got %b expected %b", got, exp);
        end
    endtask

    // ap_start held high; actor_done at edge 1 (START, ignored) and edges 3, 8.
    task automatic test_back_to_back();
        outs_t got, exp;
        outs_t seq [11] = '{O_START, O_RUN, O_RUN, O_DONE, O_IDLE, O_START,
                            O_RUN, O_RUN, O_DONE, O_IDLE, O_START};
        int    starts = 0;
        ap_start = 1'b1;
        for (int e = 0; e < 11; e++) begin
            actor_done = (e == 1 || e == 3 || e == 8) ? 4'hF : 4'h0;
            exp_q.push_back(seq[e]);
            tick();
            if (trigger_start != '0) starts++;
            got = snap(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back edge %0d: got %b expected %b", e, got, exp);
            end
        end
        checks++;
        if (starts !== 3) begin
            failures++;
            $display("FAIL b2b_start_count: got %0d expected 3", starts);
        end
        ap_start   = 1'b0;
        actor_done = '0;
        tick();
        finish_run();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_sleep_gating();
        test_enqueue_hold();
        test_sync_reductions();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
